or1200_dslot_monitor: RTL and testbench
=======================================

Name: or1200_dslot_monitor

Overview:
- Synthesisable, parametrised run-time checker for the OR1200 pipeline control.
- Keeps a shadow copy of the ID..WB pipeline (valid, branch, delay-slot bits) driven by the per-stage freeze and flush controls.
- Checks four delay-slot and freeze invariants in silicon or emulation.
- Reports violations through sticky flags, a saturating counter, a first-failure capture and an interrupt; sits beside or1200_ctrl.

Parameters:
- STAGES, 3: number of tracked stages; index 0 is ID, index STAGES-1 is the last stage. Legal range 2..8.
- CNT_W, 16: width of the violation counter.
- TS_W, 32: width of the cycle timestamp.
- DSLOT_TMO, 8: maximum number of cycles between a branch leaving ID and its delay slot entering ID. Legal range 1..255.
- IRQ_EN, 1: when 1, irq follows err_any; when 0, irq is tied to 0.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- freeze  input  STAGES  per-stage freeze; bit 0 is ID
- flush  input  STAGES  per-stage flush; clears that stage's shadow entry
- id_valid  input  1  ID holds a real (non-void) instruction this cycle
- id_branch  input  1  instruction in ID is a branch or jump with a delay slot
- chk_en  input  4  per-check enable
- clr  input  1  synchronous clear of all error state
- err_sticky  output  4  sticky per-check violation flags
- err_any  output  1  OR of err_sticky
- err_cnt  output  CNT_W  saturating count of violation events
- first_id  output  2  index of the first violated check
- first_ts  output  TS_W  timestamp of the first violation
- irq  output  1  error interrupt

Behaviour:
- Reset: asserting rst (low) clears all shadow entries, the timeout counter, the timestamp and every output to 0, immediately and asynchronously. This holds when reset arrives mid-window as well.
- Timestamp counter: free-running, +1 per cycle, wraps to 0.
- Shadow entry per stage s: {v, br, ds}.
  - Stage 0 loads {id_valid, id_branch, pend_ds & id_valid} when !freeze[0].
  - Stage s>0 loads entry s-1 when !freeze[s].
  - If freeze[s-1] & !freeze[s], stage s loads a bubble (all bits 0).
  - flush[s] forces entry s to 0 and takes priority over the load.
- pend_ds:
  - Set when stage 0 advances with br=1.
  - Cleared when a valid instruction enters stage 0.
  - Also cleared by flush[0].
- Checks, evaluated each cycle, each gated by chk_en[i]:
  - C0 freeze order: violation when freeze[s] & !freeze[s-1] for any s>=1. A later stage is frozen while an earlier stage runs.
  - C1 branch in delay slot: violation when an entry with ds=1 and br=1 is loaded into stage 0.
  - C2 delay-slot timeout: the timeout counter runs while pend_ds=1 and resets when pend_ds=0. Violation on the cycle the count reaches DSLOT_TMO; the check then fires only once per pending slot.
  - C3 orphan delay slot: violation when flush[s] clears an entry whose next-older stage s+1 holds br=1 with v=1 and flush[s+1]=0. The delay slot is flushed while its branch survives. The last stage is exempt.
- Violation event: any enabled check fires in a cycle.
  - Sets the matching err_sticky bits on the next edge.
  - Adds 1 to err_cnt per cycle, not per check. err_cnt saturates at all-ones.
  - When err_any was 0, captures first_id and first_ts. If several checks fire at once, the lowest index wins.
- Latency: flags, count and capture update one cycle after the offending inputs. irq is registered, equal to err_any when IRQ_EN=1.
- clr clears err_sticky, err_cnt, first_id and first_ts. A violation in the same cycle as clr wins: the state after the edge reflects only that violation, with err_cnt=1.
- clr does not clear the shadow pipeline or the timestamp.
- chk_en changes take effect the same cycle. Disabling a check does not clear its sticky flag.

Decomposition:
- Package or1200_mon_pkg holds:
  - check-index constants CHK_FREEZE=0, CHK_BR_IN_DS=1, CHK_DS_TMO=2, CHK_ORPHAN_DS=3;
  - NCHK=4;
  - the shadow-entry struct {v, br, ds}.
- One sub-module, or1200_mon_errlog: sticky flags, saturating counter, first-failure capture and clr priority. It is reusable by other monitors.

Test Plan:
- Reset mid-run: rst low for 1 cycle during a pending delay slot -> all outputs 0 the same cycle, pend_ds=0, no C2 afterwards.
- Branch then delay slot, STAGES=3, freeze=0: id_branch=1 at cycle 0, id_valid=1 at cycle 1 -> stage 2 shows ds=1 at cycle 3, err_any stays 0.
- Freeze order: freeze=3'b100 for 1 cycle at timestamp 10 -> err_sticky=4'b0001, first_id=0, first_ts=10, err_cnt=1, irq=1 one cycle later.
- Timeout, DSLOT_TMO=8: branch leaves ID, then freeze[0]=1 for 12 cycles -> C2 fires once, err_cnt=1. Repeat with a 7-cycle freeze -> no error.
- Simultaneous events: C1 and C3 in the same cycle with err_any=0 -> err_sticky=4'b1010, first_id=1, err_cnt=1. Next test: clr with a C0 violation in the same cycle -> err_sticky=4'b0001, err_cnt=1.
- Saturation, CNT_W=4: 20 consecutive violation cycles -> err_cnt=15 and it holds there.

Source files
------------

// File: rtl/or1200_mon_pkg.sv
// Shared definitions for the OR1200 pipeline-control monitors: check indices,
// the shadow pipeline entry and a lowest-set-bit helper for failure capture.
package or1200_mon_pkg;

    localparam int CHK_FREEZE    = 0;
    localparam int CHK_BR_IN_DS  = 1;
    localparam int CHK_DS_TMO    = 2;
    localparam int CHK_ORPHAN_DS = 3;
    localparam int NCHK          = 4;

    typedef struct packed {
        logic v;
        logic br;
        logic ds;
    } shadow_t;

    // Lowest set index wins when several checks fire together.
    function automatic logic [1:0] first_set(input logic [NCHK-1:0] bits);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NCHK - 1; i >= 0; i--) begin
            if (bits[i]) begin
                idx = 2'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/or1200_mon_errlog.sv
// Generic error logger: sticky flags, saturating event counter, first-failure
// capture and interrupt; a violation in the same cycle as clr survives the clear.
import or1200_mon_pkg::*;

module or1200_mon_errlog #(
    parameter int CNT_W  = 16,
    parameter int TS_W   = 32,
    parameter int IRQ_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [NCHK-1:0]   viol,
    input  logic [TS_W-1:0]   ts,
    output logic [NCHK-1:0]   err_sticky,
    output logic              err_any,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [1:0]        first_id,
    output logic [TS_W-1:0]   first_ts,
    output logic              irq
);

    logic              ev_s;
    logic              cap_s;
    logic [NCHK-1:0]   sticky_nxt_s;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic [1:0]        id_nxt_s;
    logic [TS_W-1:0]   ts_nxt_s;

    // Next error state; clr zeroes history before the current cycle's violations apply.
    always_comb begin
        ev_s  = |viol;
        cap_s = ev_s & (clr | ~err_any);
        if (clr) begin
            sticky_nxt_s = viol;
            cnt_nxt_s    = ev_s ? CNT_W'(1) : {CNT_W{1'b0}};
        end else begin
            sticky_nxt_s = err_sticky | viol;
            cnt_nxt_s    = (ev_s && (err_cnt != {CNT_W{1'b1}})) ? err_cnt + CNT_W'(1) : err_cnt;
        end
        if (cap_s) begin
            id_nxt_s = first_set(viol);
            ts_nxt_s = ts;
        end else if (clr) begin
            id_nxt_s = 2'd0;
            ts_nxt_s = {TS_W{1'b0}};
        end else begin
            id_nxt_s = first_id;
            ts_nxt_s = first_ts;
        end
    end

    // Error state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_sticky <= {NCHK{1'b0}};
            err_any    <= 1'b0;
            err_cnt    <= {CNT_W{1'b0}};
            first_id   <= 2'd0;
            first_ts   <= {TS_W{1'b0}};
            irq        <= 1'b0;
        end else begin
            err_sticky <= sticky_nxt_s;
            err_any    <= |sticky_nxt_s;
            err_cnt    <= cnt_nxt_s;
            first_id   <= id_nxt_s;
            first_ts   <= ts_nxt_s;
            irq        <= (IRQ_EN != 0) & (|sticky_nxt_s);
        end
    end

endmodule

// File: rtl/or1200_dslot_monitor.sv
// Run-time checker for OR1200 freeze/flush and delay-slot rules, tracking a
// shadow copy of the ID..WB valid/branch/delay-slot bits.
import or1200_mon_pkg::*;

module or1200_dslot_monitor #(
    parameter int STAGES    = 3,
    parameter int CNT_W     = 16,
    parameter int TS_W      = 32,
    parameter int DSLOT_TMO = 8,
    parameter int IRQ_EN    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] freeze,
    input  logic [STAGES-1:0] flush,
    input  logic              id_valid,
    input  logic              id_branch,
    input  logic [NCHK-1:0]   chk_en,
    input  logic              clr,
    output logic [NCHK-1:0]   err_sticky,
    output logic              err_any,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [1:0]        first_id,
    output logic [TS_W-1:0]   first_ts,
    output logic              irq
);

    // Enough room to count one past the largest timeout so the check fires once.
    localparam int TMO_W = 9;

    shadow_t           sh_r     [STAGES];
    shadow_t           sh_nxt_s [STAGES];
    logic              pend_ds_r;
    logic              pend_nxt_s;
    logic [TMO_W-1:0]  tmo_r;
    logic [TMO_W-1:0]  tmo_nxt_s;
    logic [TS_W-1:0]   ts_r;
    logic              load0_s;
    logic              restart_s;
    logic              c0_s, c1_s, c2_s, c3_s;
    logic [NCHK-1:0]   viol_s;

    // Shadow pipeline, pending delay slot and timeout next-state.
    always_comb begin
        load0_s   = ~freeze[0] & ~flush[0];
        restart_s = load0_s & (id_valid | id_branch);
        if (flush[0]) begin
            sh_nxt_s[0] = 3'b000;
        end else if (!freeze[0]) begin
            sh_nxt_s[0] = {id_valid, id_branch, pend_ds_r & id_valid};
        end else begin
            sh_nxt_s[0] = sh_r[0];
        end
        for (int s = 1; s < STAGES; s++) begin
            if (flush[s]) begin
                sh_nxt_s[s] = 3'b000;
            end else if (freeze[s]) begin
                sh_nxt_s[s] = sh_r[s];
            end else if (freeze[s-1]) begin
                sh_nxt_s[s] = 3'b000;
            end else begin
                sh_nxt_s[s] = sh_r[s-1];
            end
        end
        if (flush[0]) begin
            pend_nxt_s = 1'b0;
        end else if (load0_s & id_branch) begin
            pend_nxt_s = 1'b1;
        end else if (load0_s & id_valid) begin
            pend_nxt_s = 1'b0;
        end else begin
            pend_nxt_s = pend_ds_r;
        end
        if (!pend_ds_r || restart_s) begin
            tmo_nxt_s = {TMO_W{1'b0}};
        end else if (tmo_r <= TMO_W'(DSLOT_TMO)) begin
            tmo_nxt_s = tmo_r + TMO_W'(1);
        end else begin
            tmo_nxt_s = tmo_r;
        end
    end

    // Invariant checks on the current inputs and shadow state.
    always_comb begin
        c0_s = 1'b0;
        for (int s = 1; s < STAGES; s++) begin
            c0_s = c0_s | (freeze[s] & ~freeze[s-1]);
        end
        c1_s = load0_s & id_valid & id_branch & pend_ds_r;
        c2_s = pend_ds_r & (tmo_r == TMO_W'(DSLOT_TMO));
        c3_s = 1'b0;
        for (int s = 0; s < STAGES - 1; s++) begin
            c3_s = c3_s | (flush[s] & sh_r[s+1].v & sh_r[s+1].br & ~flush[s+1]);
        end
        viol_s = chk_en & {c3_s, c2_s, c1_s, c0_s};
    end

    // Shadow pipeline, timeout and timestamp registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < STAGES; s++) begin
                sh_r[s] <= 3'b000;
            end
            pend_ds_r <= 1'b0;
            tmo_r     <= {TMO_W{1'b0}};
            ts_r      <= {TS_W{1'b0}};
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                sh_r[s] <= sh_nxt_s[s];
            end
            pend_ds_r <= pend_nxt_s;
            tmo_r     <= tmo_nxt_s;
            ts_r      <= ts_r + TS_W'(1);
        end
    end

    or1200_mon_errlog #(
        .CNT_W  (CNT_W),
        .TS_W   (TS_W),
        .IRQ_EN (IRQ_EN)
    ) u_errlog (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .viol       (viol_s),
        .ts         (ts_r),
        .err_sticky (err_sticky),
        .err_any    (err_any),
        .err_cnt    (err_cnt),
        .first_id   (first_id),
        .first_ts   (first_ts),
        .irq        (irq)
    );

endmodule

// File: tb/tb_or1200_dslot_monitor.sv
// Directed scenarios plus randomized traffic checked each cycle against a
// cycle-level model of the monitor's rules.
module tb_or1200_dslot_monitor;

    localparam int ST  = 3;
    localparam int CW  = 4;
    localparam int TW  = 32;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [ST-1:0] freeze, flush;
    logic          id_valid, id_branch;
    logic [3:0]    chk_en;
    logic          clr;
    logic [3:0]    err_sticky;
    logic          err_any;
    logic [CW-1:0] err_cnt;
    logic [1:0]    first_id;
    logic [TW-1:0] first_ts;
    logic          irq;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit        mv [ST];
    bit        mbr[ST];
    bit        mds[ST];
    bit        mpend;
    int        mage;
    bit [31:0] mts;
    bit [3:0]  msticky;
    int        mcnt;
    int        mfid;
    bit [31:0] mfts;

    or1200_dslot_monitor #(
        .STAGES(ST), .CNT_W(CW), .TS_W(TW), .DSLOT_TMO(TMO), .IRQ_EN(1)
    ) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .id_valid(id_valid), .id_branch(id_branch), .chk_en(chk_en), .clr(clr),
        .err_sticky(err_sticky), .err_any(err_any), .err_cnt(err_cnt),
        .first_id(first_id), .first_ts(first_ts), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < ST; s++) begin
            mv[s] = 0; mbr[s] = 0; mds[s] = 0;
        end
        mpend = 0; mage = 0; mts = 0;
        msticky = 0; mcnt = 0; mfid = 0; mfts = 0;
    endtask

    task automatic model_edge();
        bit c0, c1, c2, c3;
        bit [3:0] v;
        bit load0;
        c0 = 0;
        for (int s = 1; s < ST; s++) if (freeze[s] && !freeze[s-1]) c0 = 1;
        load0 = !freeze[0] && !flush[0];
        c1 = load0 && id_valid && id_branch && mpend;
        c2 = mpend && (mage == TMO + 1);
        c3 = 0;
        for (int s = 0; s < ST - 1; s++)
            if (flush[s] && mv[s+1] && mbr[s+1] && !flush[s+1]) c3 = 1;
        v = {c3, c2, c1, c0} & chk_en;
        if (clr) begin
            msticky = 0; mcnt = 0; mfid = 0; mfts = 0;
        end
        if (v != 0) begin
            if (msticky == 0) begin
                for (int i = 3; i >= 0; i--) if (v[i]) mfid = i;
                mfts = mts;
            end
            msticky |= v;
            if (mcnt < (1 << CW) - 1) mcnt++;
        end
        for (int s = ST - 1; s >= 1; s--) begin
            if (flush[s]) begin
                mv[s] = 0; mbr[s] = 0; mds[s] = 0;
            end else if (!freeze[s]) begin
                if (freeze[s-1]) begin
                    mv[s] = 0; mbr[s] = 0; mds[s] = 0;
                end else begin
                    mv[s] = mv[s-1]; mbr[s] = mbr[s-1]; mds[s] = mds[s-1];
                end
            end
        end
        if (flush[0]) begin
            mv[0] = 0; mbr[0] = 0; mds[0] = 0;
        end else if (!freeze[0]) begin
            mv[0] = id_valid; mbr[0] = id_branch; mds[0] = mpend && id_valid;
        end
        if (flush[0]) begin
            mpend = 0; mage = 0;
        end else if (load0 && id_branch) begin
            mpend = 1; mage = 1;
        end else if (load0 && id_valid) begin
            mpend = 0; mage = 0;
        end else if (mpend) begin
            mage++;
        end
        mts = mts + 1;
    endtask

    task automatic compare_all();
        check_val("sticky", 64'(err_sticky), 64'(msticky));
        check_val("any",    64'(err_any),    64'(msticky != 0));
        check_val("cnt",    64'(err_cnt),    64'(mcnt));
        check_val("fid",    64'(first_id),   64'(mfid));
        check_val("fts",    64'(first_ts),   64'(mfts));
        check_val("irq",    64'(irq),        64'(msticky != 0));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        freeze = '0; flush = '0; id_valid = 1'b0; id_branch = 1'b0; clr = 1'b0;
    endtask

    initial begin
        int guard;
        int vprob;
        rst = 1'b1;
        idle_inputs();
        chk_en = 4'hF;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        check_val("rst_sticky", 64'(err_sticky), 64'd0);
        check_val("rst_cnt",    64'(err_cnt),    64'd0);
        check_val("rst_irq",    64'(irq),        64'd0);
        rst = 1'b1;

        // Branch followed by its delay slot: no error
        id_valid = 1'b1; id_branch = 1'b1; step();
        id_branch = 1'b0; step();
        id_valid = 1'b0; repeat (3) step();
        check_val("br_ds_ok", 64'(err_any), 64'd0);

        // Freeze order violation at timestamp 10
        guard = 0;
        while (mts != 10 && guard < 50) begin
            step(); guard++;
        end
        check_val("ts_reach10", 64'(mts), 64'd10);
        freeze = 3'b100; step();
        freeze = 3'b000;
        check_val("c0_sticky", 64'(err_sticky), 64'd1);
        check_val("c0_fid",    64'(first_id),   64'd0);
        check_val("c0_fts",    64'(first_ts),   64'd10);
        check_val("c0_cnt",    64'(err_cnt),    64'd1);
        check_val("c0_irq",    64'(irq),        64'd1);
        clr = 1'b1; step(); clr = 1'b0;

        // Delay-slot timeout: 12 frozen cycles fire once
        id_valid = 1'b1; id_branch = 1'b1; step();
        id_branch = 1'b0; freeze = 3'b001; repeat (12) step();
        freeze = 3'b000; step();
        id_valid = 1'b0; step();
        check_val("tmo_sticky", 64'(err_sticky), 64'd4);
        check_val("tmo_cnt",    64'(err_cnt),    64'd1);
        clr = 1'b1; step(); clr = 1'b0;

        // 7 frozen cycles stay within the window
        id_valid = 1'b1; id_branch = 1'b1; step();
        id_branch = 1'b0; freeze = 3'b001; repeat (7) step();
        freeze = 3'b000; step();
        id_valid = 1'b0; step();
        check_val("tmo_ok", 64'(err_any), 64'd0);

        // C1 and C3 in the same cycle
        id_valid = 1'b1; id_branch = 1'b1; step();
        id_valid = 1'b0; id_branch = 1'b0; repeat (2) step();
        id_valid = 1'b1; id_branch = 1'b1; flush = 3'b010; step();
        idle_inputs();
        check_val("sim_sticky", 64'(err_sticky), 64'd10);
        check_val("sim_fid",    64'(first_id),   64'd1);
        check_val("sim_cnt",    64'(err_cnt),    64'd1);

        // clr together with a C0 violation
        clr = 1'b1; freeze = 3'b100; step();
        idle_inputs();
        check_val("clr_sticky", 64'(err_sticky), 64'd1);
        check_val("clr_cnt",    64'(err_cnt),    64'd1);
        id_valid = 1'b1; step();
        id_valid = 1'b0;

        // Counter saturation
        freeze = 3'b100; repeat (20) step();
        check_val("sat_cnt", 64'(err_cnt), 64'd15);
        repeat (2) step();
        check_val("sat_hold", 64'(err_cnt), 64'd15);
        freeze = 3'b000;

        // Reset mid-window
        id_valid = 1'b1; id_branch = 1'b1; step();
        idle_inputs(); step();
        rst = 1'b0;
        #1;
        check_val("mrst_sticky", 64'(err_sticky), 64'd0);
        check_val("mrst_any",    64'(err_any),    64'd0);
        check_val("mrst_cnt",    64'(err_cnt),    64'd0);
        check_val("mrst_fts",    64'(first_ts),   64'd0);
        check_val("mrst_irq",    64'(irq),        64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (12) step();
        check_val("mrst_no_tmo", 64'(err_any), 64'd0);

        // Randomized traffic
        for (int blk = 0; blk < 8; blk++) begin
            vprob = (blk % 2 == 0) ? 3 : 9;
            for (int c = 0; c < 100; c++) begin
                freeze    = ($urandom_range(0, 9) < 7) ? 3'b000 : 3'($urandom_range(0, 7));
                flush     = ($urandom_range(0, 9) < 8) ? 3'b000 : 3'($urandom_range(0, 7));
                id_valid  = ($urandom_range(0, 9) < vprob);
                id_branch = ($urandom_range(0, 3) == 0);
                chk_en    = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom_range(0, 15));
                clr       = ($urandom_range(0, 19) == 0);
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
